// File: rtl/stack_unit.sv
// Hardware stack for the 16-bit processor: storage, stack pointer and count in one block.
// It also provides full/empty status and sticky overflow/underflow flags for trapping stack misuse.
module stack_unit #(
  parameter int          DATA_W    = 16,
  parameter int          DEPTH     = 16,
  parameter int          ADDR_W    = 16,
  parameter int unsigned SP_BASE   = 'hFFFF,
  parameter bit          GROW_DOWN = 1'b1,
  localparam int         CNT_W     = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] sp,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_BASE);
  localparam logic [ADDR_W-1:0] SP_STEP = GROW_DOWN ? '1 : ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_sp;
  logic              r_ovf, r_unf;

  logic              w_full, w_empty;
  logic              w_inc, w_dec, w_repl, w_we, w_ovf, w_unf;
  logic [CNT_W-1:0]  w_wr_idx;
  logic [DATA_W-1:0] w_top;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Push+pop on an empty stack degrades to a plain push.
  assign w_inc    = push & ~w_full & (~pop | w_empty);
  assign w_dec    = pop & ~push & ~w_empty;
  assign w_repl   = push & pop & ~w_empty;
  assign w_we     = w_inc | w_repl;
  assign w_ovf    = push & ~pop & w_full;
  assign w_unf    = pop & ~push & w_empty;
  assign w_wr_idx = w_repl ? r_count - CNT_W'(1) : r_count;

  always_comb begin
    w_top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_count == CNT_W'(i + 1)) w_top = r_mem[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_sp    <= SP_INIT;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_inc) begin
        r_count <= r_count + CNT_W'(1);
        r_sp    <= r_sp + SP_STEP;
      end else if (w_dec) begin
        r_count <= r_count - CNT_W'(1);
        r_sp    <= r_sp - SP_STEP;
      end
      r_ovf <= w_ovf | (r_ovf & ~clr_err);
      r_unf <= w_unf | (r_unf & ~clr_err);
    end
  end

  // Storage has no reset; the write is gated so a push coincident with reset is dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (reset && w_we && w_wr_idx == CNT_W'(i)) r_mem[i] <= din;
  end

  assign dout      = w_top;
  assign sp        = r_sp;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: a grow-down instance at base 00FF and a grow-up instance at base FFFE.
module tb_stack_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        rst_d, push_d, pop_d, clr_d;
  logic [15:0] din_d, dout_d, sp_d;
  logic [2:0]  cnt_d;
  logic        full_d, empty_d, ovf_d, unf_d;

  logic        rst_u, push_u, pop_u, clr_u;
  logic [15:0] din_u, dout_u, sp_u;
  logic [2:0]  cnt_u;
  logic        full_u, empty_u, ovf_u, unf_u;

  stack_unit #(.DATA_W(16), .DEPTH(4), .ADDR_W(16), .SP_BASE('h00FF), .GROW_DOWN(1'b1)) u_dn (
    .clk(clk), .reset(rst_d), .push(push_d), .pop(pop_d), .din(din_d), .clr_err(clr_d),
    .dout(dout_d), .sp(sp_d), .count(cnt_d), .full(full_d), .empty(empty_d),
    .overflow(ovf_d), .underflow(unf_d));

  stack_unit #(.DATA_W(16), .DEPTH(4), .ADDR_W(16), .SP_BASE('hFFFE), .GROW_DOWN(1'b0)) u_up (
    .clk(clk), .reset(rst_u), .push(push_u), .pop(pop_u), .din(din_u), .clr_err(clr_u),
    .dout(dout_u), .sp(sp_u), .count(cnt_u), .full(full_u), .empty(empty_u),
    .overflow(ovf_u), .underflow(unf_u));

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op_d(input logic ps, input logic pp, input logic [15:0] d, input logic ce);
    push_d = ps; pop_d = pp; din_d = d; clr_d = ce;
    step();
    push_d = 1'b0; pop_d = 1'b0; clr_d = 1'b0;
  endtask

  task automatic test_reset();
    op_d(1'b1, 1'b0, 16'h1234, 1'b0);
    #2 rst_d = 1'b0;
    #1;
    n_tests++; if (sp_d !== 16'h00FF) begin n_fail++; $display("FAIL reset_sp got %h exp 00ff", sp_d); end
    n_tests++; if (cnt_d !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", cnt_d); end
    n_tests++; if (empty_d !== 1'b1 || full_d !== 1'b0) begin n_fail++; $display("FAIL reset_status got e=%b f=%b exp e=1 f=0", empty_d, full_d); end
    n_tests++; if (dout_d !== 16'h0000) begin n_fail++; $display("FAIL reset_dout got %h exp 0000", dout_d); end
    n_tests++; if (ovf_d !== 1'b0 || unf_d !== 1'b0) begin n_fail++; $display("FAIL reset_flags got o=%b u=%b exp 0 0", ovf_d, unf_d); end
    step();
    rst_d = 1'b1;
    step();
  endtask

  task automatic test_fill_drain();
    logic [15:0] vals [4];
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) op_d(1'b1, 1'b0, vals[i], 1'b0);
    n_tests++; if (sp_d !== 16'h00FB) begin n_fail++; $display("FAIL fill_sp got %h exp 00fb", sp_d); end
    n_tests++; if (full_d !== 1'b1 || cnt_d !== 3'd4) begin n_fail++; $display("FAIL fill_full got f=%b c=%0d exp f=1 c=4", full_d, cnt_d); end
    n_tests++; if (dout_d !== 16'h4444) begin n_fail++; $display("FAIL fill_dout got %h exp 4444", dout_d); end
    for (int i = 3; i >= 0; i--) begin
      pop_d = 1'b1;
      #1;
      n_tests++; if (dout_d !== vals[i]) begin n_fail++; $display("FAIL drain_dout%0d got %h exp %h", i, dout_d, vals[i]); end
      step();
      pop_d = 1'b0;
    end
    n_tests++; if (sp_d !== 16'h00FF || empty_d !== 1'b1) begin n_fail++; $display("FAIL drain_end got sp=%h e=%b exp sp=00ff e=1", sp_d, empty_d); end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 4; i++) op_d(1'b1, 1'b0, 16'h1000 + 16'(i), 1'b0);
    op_d(1'b1, 1'b0, 16'h5555, 1'b0);
    n_tests++; if (cnt_d !== 3'd4 || sp_d !== 16'h00FB || dout_d !== 16'h1003) begin n_fail++; $display("FAIL ovf_hold got c=%0d sp=%h d=%h exp c=4 sp=00fb d=1003", cnt_d, sp_d, dout_d); end
    n_tests++; if (ovf_d !== 1'b1 || unf_d !== 1'b0) begin n_fail++; $display("FAIL ovf_flag got o=%b u=%b exp o=1 u=0", ovf_d, unf_d); end
    for (int i = 0; i < 4; i++) op_d(1'b0, 1'b1, 16'h0, 1'b0);
    op_d(1'b0, 1'b1, 16'h0, 1'b0);
    n_tests++; if (unf_d !== 1'b1 || ovf_d !== 1'b1 || cnt_d !== 3'd0 || sp_d !== 16'h00FF) begin n_fail++; $display("FAIL unf_flag got u=%b o=%b c=%0d sp=%h exp u=1 o=1 c=0 sp=00ff", unf_d, ovf_d, cnt_d, sp_d); end
    op_d(1'b0, 1'b0, 16'h0, 1'b1);
    n_tests++; if (unf_d !== 1'b0 || ovf_d !== 1'b0) begin n_fail++; $display("FAIL clr_err got o=%b u=%b exp 0 0", ovf_d, unf_d); end
    op_d(1'b0, 1'b1, 16'h0, 1'b1);
    n_tests++; if (unf_d !== 1'b1 || ovf_d !== 1'b0) begin n_fail++; $display("FAIL clr_vs_set got u=%b o=%b exp u=1 o=0", unf_d, ovf_d); end
    op_d(1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_replace();
    op_d(1'b1, 1'b0, 16'hAAAA, 1'b0);
    op_d(1'b1, 1'b0, 16'hBBBB, 1'b0);
    op_d(1'b1, 1'b1, 16'hCCCC, 1'b0);
    n_tests++; if (cnt_d !== 3'd2 || sp_d !== 16'h00FD || dout_d !== 16'hCCCC) begin n_fail++; $display("FAIL repl_top got c=%0d sp=%h d=%h exp c=2 sp=00fd d=cccc", cnt_d, sp_d, dout_d); end
    op_d(1'b0, 1'b1, 16'h0, 1'b0);
    n_tests++; if (dout_d !== 16'hAAAA || cnt_d !== 3'd1) begin n_fail++; $display("FAIL repl_pop got d=%h c=%0d exp d=aaaa c=1", dout_d, cnt_d); end
    op_d(1'b0, 1'b1, 16'h0, 1'b0);
    op_d(1'b1, 1'b1, 16'h0042, 1'b0);
    n_tests++; if (cnt_d !== 3'd1 || dout_d !== 16'h0042 || sp_d !== 16'h00FE) begin n_fail++; $display("FAIL repl_empty got c=%0d d=%h sp=%h exp c=1 d=0042 sp=00fe", cnt_d, dout_d, sp_d); end
    n_tests++; if (unf_d !== 1'b0 || ovf_d !== 1'b0) begin n_fail++; $display("FAIL repl_flags got u=%b o=%b exp 0 0", unf_d, ovf_d); end
    op_d(1'b0, 1'b1, 16'h0, 1'b0);
  endtask

  task automatic test_wrap();
    n_tests++; if (sp_u !== 16'hFFFE || empty_u !== 1'b1) begin n_fail++; $display("FAIL up_reset got sp=%h e=%b exp fffe 1", sp_u, empty_u); end
    push_u = 1'b1; din_u = 16'h0A0A; step();
    n_tests++; if (sp_u !== 16'hFFFF) begin n_fail++; $display("FAIL up_push1 got sp=%h exp ffff", sp_u); end
    din_u = 16'h0B0B; step();
    push_u = 1'b0;
    n_tests++; if (sp_u !== 16'h0000 || cnt_u !== 3'd2 || dout_u !== 16'h0B0B) begin n_fail++; $display("FAIL up_wrap got sp=%h c=%0d d=%h exp 0000 2 0b0b", sp_u, cnt_u, dout_u); end
    n_tests++; if (ovf_u !== 1'b0 || unf_u !== 1'b0) begin n_fail++; $display("FAIL up_flags got o=%b u=%b exp 0 0", ovf_u, unf_u); end
    pop_u = 1'b1; step(); step();
    pop_u = 1'b0;
    n_tests++; if (sp_u !== 16'hFFFE || empty_u !== 1'b1) begin n_fail++; $display("FAIL up_drain got sp=%h e=%b exp fffe 1", sp_u, empty_u); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) op_d(1'b1, 1'b0, 16'h2000 + 16'(i), 1'b0);
    op_d(1'b0, 1'b1, 16'h0, 1'b0);
    op_d(1'b0, 1'b1, 16'h0, 1'b0);
    op_d(1'b0, 1'b1, 16'h0, 1'b0);
    op_d(1'b0, 1'b1, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) op_d(1'b1, 1'b0, 16'h3000 + 16'(i), 1'b0);
    push_d = 1'b1; din_d = 16'h7777;
    @(posedge clk);
    rst_d = 1'b0;
    #1;
    push_d = 1'b0;
    n_tests++; if (cnt_d !== 3'd0 || sp_d !== 16'h00FF || dout_d !== 16'h0000) begin n_fail++; $display("FAIL rstmid_state got c=%0d sp=%h d=%h exp 0 00ff 0000", cnt_d, sp_d, dout_d); end
    n_tests++; if (ovf_d !== 1'b0 || unf_d !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags got o=%b u=%b exp 0 0", ovf_d, unf_d); end
    step();
    rst_d = 1'b1;
    op_d(1'b1, 1'b0, 16'h9999, 1'b0);
    n_tests++; if (dout_d !== 16'h9999 || cnt_d !== 3'd1 || sp_d !== 16'h00FE) begin n_fail++; $display("FAIL rstmid_push got d=%h c=%0d sp=%h exp 9999 1 00fe", dout_d, cnt_d, sp_d); end
  endtask

  initial begin
    rst_d = 1'b0; push_d = 1'b0; pop_d = 1'b0; din_d = '0; clr_d = 1'b0;
    rst_u = 1'b0; push_u = 1'b0; pop_u = 1'b0; din_u = '0; clr_u = 1'b0;
    step(); step();
    rst_d = 1'b1; rst_u = 1'b1;
    step();
    test_reset();
    test_fill_drain();
    test_errors();
    test_replace();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/stack_unit.md
# stack_unit

Parametrised hardware stack for the 16-bit processor: combines the stack pointer register, its increment/decrement logic and the stack storage in one block. It holds up to DEPTH words and exposes the live top-of-stack, the architectural stack pointer, and full/empty status. Sticky overflow and underflow error flags are added so the control unit can trap on stack misuse. It sits beside the register file and is driven by the control unit's push/pop strobes.

## Interface
- DATA_W, 16, width of stored words
- DEPTH, 16, number of entries (≥2, need not be a power of two)
- ADDR_W, 16, width of the sp output
- SP_BASE, 16'hFFFF, sp value when the stack is empty (truncated/extended to ADDR_W)
- GROW_DOWN, 1, 1: push decrements sp; 0: push increments sp
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- push  input  1  push din this cycle
- pop  input  1  pop top entry this cycle
- din  input  DATA_W  data to push
- clr_err  input  1  clears overflow/underflow
- dout  output  DATA_W  current top-of-stack; 0 when empty
- sp  output  ADDR_W  stack pointer
- count  output  $clog2(DEPTH+1)  occupied entries
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  sticky: push attempted while full
- underflow  output  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH×DATA_W flops, entry index 0 = bottom; top = mem[count-1]. Storage is not reset.
- Invariant: sp = SP_BASE − count (GROW_DOWN=1) or SP_BASE + count (GROW_DOWN=0), modulo 2^ADDR_W; wrap-around of sp is legal, not an error.
- push only, not full: mem[count] ← din; count+1; sp moves one step in growth direction.
- push only, full: no state change; overflow ← 1.
- pop only, not empty: count−1; sp moves one step back. Popped data is the dout value presented in that same cycle.
- pop only, empty: no state change; underflow ← 1.
- push and pop, not empty: replace top: mem[count-1] ← din; count and sp unchanged; no flag set (also when full).
- push and pop, empty: treated as push only; no underflow.
- Neither: hold.
- clr_err: clears both sticky flags; if a new error occurs in the same cycle, set wins.
- full, empty, dout: combinational from registered state only (no input-to-output paths).

## Timing
- Reset (reset=0), asynchronous: count=0, sp=SP_BASE, overflow=0, underflow=0, hence empty=1, full=0, dout=0; effective immediately, independent of clk. Push/pop ignored while reset is low. Reset during a push loses that push.
- Latency: push at edge N → dout=din, count, sp, full updated after edge N (visible in cycle N+1). Pop likewise one edge.
- Back-to-back push/pop every cycle supported, no bubbles.
- Error flags assert after the offending edge and stay set until clr_err or reset.

## Test plan
- Reset: DEPTH=4, SP_BASE=16'h00FF, GROW_DOWN=1; drive reset=0 mid-cycle → sp=00FF, count=0, empty=1, dout=0 immediately, before the next clk edge.
- Fill/drain: push 0x1111, 0x2222, 0x3333, 0x4444 → sp=00FB, full=1, dout=4444; four pops → dout sequence 4444, 3333, 2222, 1111 on pop cycles, final sp=00FF, empty=1.
- Overflow/underflow: 5th push when full → state unchanged, overflow=1; pop on empty → underflow=1; clr_err → both 0; clr_err concurrent with bad pop → underflow stays 1.
- Replace top: stack [AAAA, BBBB], push+pop with din=CCCC → count=2, sp unchanged, dout=CCCC; one pop → dout=AAAA. Push+pop on empty with din=0x0042 → count=1, dout=0042, underflow=0.
- Wrap/direction: GROW_DOWN=0, SP_BASE=16'hFFFE, two pushes → sp=0000, no error flags; two pops → sp=FFFE.
- Reset mid-operation: three pushes, then assert reset coincident with a push edge → count=0, sp=SP_BASE, flags 0; a subsequent push after reset release yields dout = new din, count=1.
